// File: rtl/cmos_dvp_pkg.sv
`default_nettype none
// ============================================================================
// cmos_dvp_pkg : state encoding, default timing and colour-bar palette
// Revision     : 1.0
// ============================================================================
package cmos_dvp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_BACK   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_FRONT  = 3'd4
    } dvp_state_t;

    localparam int C_H_ACTIVE = 640;
    localparam int C_H_BLANK  = 144;
    localparam int C_V_ACTIVE = 480;
    localparam int C_V_SYNC   = 4;
    localparam int C_V_BACK   = 16;
    localparam int C_V_FRONT  = 8;

    localparam logic [15:0] C_BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] C_BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] C_BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] C_BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] C_BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] C_BAR_RED     = 16'hF800;
    localparam logic [15:0] C_BAR_BLUE    = 16'h001F;
    localparam logic [15:0] C_BAR_BLACK   = 16'h0000;

    function automatic logic [15:0] bar_color(input logic [2:0] bar);
        case (bar)
            3'd0:    return C_BAR_WHITE;
            3'd1:    return C_BAR_YELLOW;
            3'd2:    return C_BAR_CYAN;
            3'd3:    return C_BAR_GREEN;
            3'd4:    return C_BAR_MAGENTA;
            3'd5:    return C_BAR_RED;
            3'd6:    return C_BAR_BLUE;
            default: return C_BAR_BLACK;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmos_testpat_gen.sv
`default_nettype none
// ============================================================================
// cmos_testpat_gen : maps a pixel index within the line to an 8-bar colour
// Revision         : 1.0
// ============================================================================
module cmos_testpat_gen
    import cmos_dvp_pkg::*;
#(
    parameter int H_ACTIVE = C_H_ACTIVE,
    parameter int IDX_W    = 10
) (
    input  logic [IDX_W-1:0] pix_idx,
    output logic [15:0]      pix
);

    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0] w_bar;

    generate
        if (BAR_W == 0) begin : g_narrow
            // Every bar is zero pixels wide, so the whole line is remainder.
            logic w_unused_idx;
            assign w_unused_idx = ^pix_idx;
            assign w_bar        = 3'd7;
        end else begin : g_bars
            logic [31:0] w_quot;
            assign w_quot = 32'(pix_idx) / 32'(BAR_W);
            assign w_bar  = (w_quot > 32'd7) ? 3'd7 : w_quot[2:0];
        end
    endgenerate

    assign pix = bar_color(w_bar);

endmodule
`default_nettype wire

// File: rtl/cmos_dvp_tx.sv
`default_nettype none
// ============================================================================
// cmos_dvp_tx : RGB565 to 8-bit DVP sender; optional colour bars under
//               CMOS_DVP_TX_TESTPAT_EN
// Revision    : 1.0
// ============================================================================
module cmos_dvp_tx
    import cmos_dvp_pkg::*;
#(
    parameter int H_ACTIVE = C_H_ACTIVE,
    parameter int H_BLANK  = C_H_BLANK,
    parameter int V_ACTIVE = C_V_ACTIVE,
    parameter int V_SYNC   = C_V_SYNC,
    parameter int V_BACK   = C_V_BACK,
    parameter int V_FRONT  = C_V_FRONT
) (
    input  logic        cam_pclk,
    input  logic        rst_n,
    input  logic        frame_en,
    input  logic        test_mode,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic [7:0]  cam_data,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic        underflow
);

    localparam int LINE_LEN  = 2 * H_ACTIVE + H_BLANK;
    localparam int ACT_BYTES = 2 * H_ACTIVE;
    localparam int V_MAX_A   = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
    localparam int V_MAX_B   = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int V_MAX     = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
    localparam int LW        = $clog2(V_MAX + 1);
    localparam int CW        = $clog2(LINE_LEN);

    dvp_state_t    r_state, w_state_nxt;
    logic [LW-1:0] r_line, w_line_nxt, w_last_line;
    logic [CW-1:0] r_cyc, w_cyc_nxt;
    logic          w_href_nxt, w_even_nxt, w_req_nxt, w_done_nxt;
    logic          w_tp_sel;
    logic [15:0]   w_tp_pix, w_pix;
    logic [7:0]    r_low;

    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_line  <= '0;
            r_cyc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_line  <= w_line_nxt;
            r_cyc   <= w_cyc_nxt;
        end
    end

    always_comb begin
        case (r_state)
            ST_SYNC:   w_last_line = LW'(V_SYNC - 1);
            ST_BACK:   w_last_line = LW'(V_BACK - 1);
            ST_ACTIVE: w_last_line = LW'(V_ACTIVE - 1);
            default:   w_last_line = LW'(V_FRONT - 1);
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_line_nxt  = r_line;
        w_cyc_nxt   = r_cyc;
        if (r_state == ST_IDLE) begin
            w_line_nxt = '0;
            w_cyc_nxt  = '0;
            if (frame_en) w_state_nxt = ST_SYNC;
        end else if (r_cyc == CW'(LINE_LEN - 1)) begin
            w_cyc_nxt = '0;
            if (r_line == w_last_line) begin
                w_line_nxt = '0;
                case (r_state)
                    ST_SYNC:   w_state_nxt = ST_BACK;
                    ST_BACK:   w_state_nxt = ST_ACTIVE;
                    ST_ACTIVE: w_state_nxt = ST_FRONT;
                    default:   w_state_nxt = frame_en ? ST_SYNC : ST_IDLE;
                endcase
            end else begin
                w_line_nxt = r_line + LW'(1);
            end
        end else begin
            w_cyc_nxt = r_cyc + CW'(1);
        end
    end

    // Outputs are decoded from the upcoming position so they land as flops.
    // A pixel request must precede every even byte cycle by exactly one cycle.
    assign w_href_nxt = (w_state_nxt == ST_ACTIVE) && (w_cyc_nxt < CW'(ACT_BYTES));
    assign w_even_nxt = ~w_cyc_nxt[0];
    assign w_done_nxt = (w_state_nxt == ST_FRONT) && (w_line_nxt == LW'(V_FRONT - 1)) &&
                        (w_cyc_nxt == CW'(LINE_LEN - 1));
    assign w_req_nxt  = ((w_state_nxt == ST_ACTIVE) && w_cyc_nxt[0] &&
                         (w_cyc_nxt < CW'(ACT_BYTES - 1))) ||
                        ((w_cyc_nxt == CW'(LINE_LEN - 1)) &&
                         (((w_state_nxt == ST_BACK) && (w_line_nxt == LW'(V_BACK - 1))) ||
                          ((w_state_nxt == ST_ACTIVE) && (w_line_nxt != LW'(V_ACTIVE - 1)))));

`ifdef CMOS_DVP_TX_TESTPAT_EN
    logic r_tp_mode;

    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_tp_mode <= 1'b0;
        end else if ((w_state_nxt == ST_SYNC) && (r_state != ST_SYNC)) begin
            r_tp_mode <= test_mode;
        end
    end

    cmos_testpat_gen #(
        .H_ACTIVE (H_ACTIVE),
        .IDX_W    (CW - 1)
    ) u_testpat (
        .pix_idx  (w_cyc_nxt[CW-1:1]),
        .pix      (w_tp_pix)
    );

    assign w_tp_sel = r_tp_mode;
`else
    logic w_unused_test_mode;
    assign w_unused_test_mode = test_mode;
    assign w_tp_sel           = 1'b0;
    assign w_tp_pix           = 16'h0000;
`endif

    assign w_pix = w_tp_sel ? w_tp_pix : (pix_valid ? pix_data : 16'h0000);

    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            pix_ready  <= 1'b0;
            cam_vsync  <= 1'b0;
            cam_href   <= 1'b0;
            cam_data   <= 8'h00;
            frame_done <= 1'b0;
            frame_cnt  <= 16'h0000;
            underflow  <= 1'b0;
            r_low      <= 8'h00;
        end else begin
            pix_ready  <= w_req_nxt & ~w_tp_sel;
            cam_vsync  <= (w_state_nxt == ST_SYNC);
            cam_href   <= w_href_nxt;
            frame_done <= w_done_nxt;
            if (frame_done) frame_cnt <= frame_cnt + 16'd1;
            if (pix_ready && !pix_valid) underflow <= 1'b1;
            if (w_href_nxt && w_even_nxt) begin
                cam_data <= w_pix[15:8];
                r_low    <= w_pix[7:0];
            end else if (w_href_nxt) begin
                cam_data <= r_low;
            end else begin
                cam_data <= 8'h00;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmos_dvp_tx.sv
`default_nettype none
// tb_cmos_dvp_tx : directed checks of frame timing, byte order, underflow,
// back-to-back frames, mid-frame reset and (with the macro) colour bars.
module tb_cmos_dvp_tx;

    localparam int H_ACTIVE = 4;
    localparam int H_BLANK  = 3;
    localparam int V_ACTIVE = 2;
    localparam int V_SYNC   = 1;
    localparam int V_BACK   = 1;
    localparam int V_FRONT  = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_en;
    logic        test_mode;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready, cam_vsync, cam_href, frame_done, underflow;
    logic [7:0]  cam_data;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    cmos_dvp_tx #(
        .H_ACTIVE (H_ACTIVE), .H_BLANK (H_BLANK), .V_ACTIVE (V_ACTIVE),
        .V_SYNC   (V_SYNC),   .V_BACK  (V_BACK),  .V_FRONT  (V_FRONT)
    ) dut (
        .cam_pclk   (clk),
        .rst_n      (rst_n),
        .frame_en   (frame_en),
        .test_mode  (test_mode),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_data   (cam_data),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .underflow  (underflow)
    );

`ifdef CMOS_DVP_TX_TESTPAT_EN
    logic        tp_frame_en, tp_test_mode, tp_pix_valid;
    logic [15:0] tp_pix_data;
    logic        tp_ready, tp_vsync, tp_href, tp_done, tp_underflow;
    logic [7:0]  tp_data;
    logic [15:0] tp_cnt;
    logic [7:0]  tp_exp [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                 8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};

    cmos_dvp_tx #(
        .H_ACTIVE (8),      .H_BLANK (H_BLANK), .V_ACTIVE (V_ACTIVE),
        .V_SYNC   (V_SYNC), .V_BACK  (V_BACK),  .V_FRONT  (V_FRONT)
    ) dut_tp (
        .cam_pclk   (clk),
        .rst_n      (rst_n),
        .frame_en   (tp_frame_en),
        .test_mode  (tp_test_mode),
        .pix_data   (tp_pix_data),
        .pix_valid  (tp_pix_valid),
        .pix_ready  (tp_ready),
        .cam_vsync  (tp_vsync),
        .cam_href   (tp_href),
        .cam_data   (tp_data),
        .frame_done (tp_done),
        .frame_cnt  (tp_cnt),
        .underflow  (tp_underflow)
    );
`endif

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] pix_tab [4] = '{16'h1234, 16'hABCD, 16'h00FF, 16'hF800};
    int          cyc, n_vs, n_hr, n_done, n_ready, n_dnz, first_hr, pix_idx, drop_idx;
    int          done_at [$];
    logic [7:0]  got [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        cyc = 0; n_vs = 0; n_hr = 0; n_done = 0; n_ready = 0; n_dnz = 0;
        first_hr = -1; pix_idx = 0;
        got.delete();
        done_at.delete();
    endtask

    // One cycle: sample at the falling edge, then serve any pixel request.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (cam_vsync) n_vs++;
        if (cam_href) begin
            n_hr++;
            got.push_back(cam_data);
            if (first_hr < 0) first_hr = cyc;
        end else if (cam_data !== 8'h00) begin
            n_dnz++;
        end
        if (frame_done) begin
            n_done++;
            done_at.push_back(cyc);
        end
        if (pix_ready) begin
            n_ready++;
            pix_data  = pix_tab[pix_idx % 4];
            pix_valid = (pix_idx != drop_idx);
            pix_idx++;
        end else begin
            pix_data  = 16'hDEAD;
            pix_valid = 1'b1;
        end
    endtask

    function automatic logic [7:0] exp_byte(input int k, input int drop);
        logic [15:0] px;
        px = ((k / 2) == drop) ? 16'h0000 : pix_tab[(k / 2) % 4];
        return (k % 2 == 0) ? px[15:8] : px[7:0];
    endfunction

    initial begin
        rst_n = 1'b0; frame_en = 1'b0; test_mode = 1'b0;
        pix_data = 16'hDEAD; pix_valid = 1'b1; drop_idx = -1;
`ifdef CMOS_DVP_TX_TESTPAT_EN
        tp_frame_en = 1'b0; tp_test_mode = 1'b1; tp_pix_valid = 1'b0; tp_pix_data = 16'h1234;
`endif
        clear_stats();
        repeat (3) @(negedge clk);
        chk("rst_vsync", cam_vsync, 1'b0);
        chk("rst_href", cam_href, 1'b0);
        chk("rst_data", cam_data, 8'h00);
        chk("rst_ready", pix_ready, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        chk("rst_cnt", frame_cnt, 16'h0000);
        chk("rst_underflow", underflow, 1'b0);
        rst_n = 1'b1;
        repeat (2) tick();
        chk("idle_vsync", cam_vsync, 1'b0);

        // Basic frame with always-valid pixels
        clear_stats();
        frame_en = 1'b1;
        tick();
        chk("vsync_first_cycle", cam_vsync, 1'b1);
        frame_en = 1'b0;
        repeat (54) tick();
        chk("done_at_55", frame_done, 1'b1);
        chk("cnt_before_update", frame_cnt, 16'd0);
        tick();
        chk("cnt_after_update", frame_cnt, 16'd1);
        repeat (5) tick();
        chk("basic_vsync_cycles", n_vs, 11);
        chk("basic_href_cycles", n_hr, 16);
        chk("basic_first_href", first_hr, 23);
        chk("basic_done_count", n_done, 1);
        chk("basic_ready_count", n_ready, 8);
        chk("basic_data_idle_zero", n_dnz, 0);
        chk("basic_underflow", underflow, 1'b0);
        chk("basic_back_to_idle", cam_vsync, 1'b0);
        for (int k = 0; k < 16; k++) chk($sformatf("basic_byte%0d", k), got[k], exp_byte(k, -1));

        // Underflow on the second pixel request
        clear_stats();
        drop_idx = 1;
        frame_en = 1'b1;
        tick();
        frame_en = 1'b0;
        repeat (60) tick();
        chk("uf_set", underflow, 1'b1);
        chk("uf_cnt", frame_cnt, 16'd2);
        for (int k = 0; k < 8; k++) chk($sformatf("uf_byte%0d", k), got[k], exp_byte(k, 1));
        clear_stats();
        drop_idx = -1;
        frame_en = 1'b1;
        tick();
        frame_en = 1'b0;
        repeat (60) tick();
        chk("uf_sticky", underflow, 1'b1);
        chk("uf_next_cnt", frame_cnt, 16'd3);
        chk("uf_next_byte2", got[2], 8'hAB);

        // Reset in the middle of an active line
        clear_stats();
        frame_en = 1'b1;
        tick();
        frame_en = 1'b0;
        repeat (24) tick();
        chk("mid_href_before", cam_href, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_href", cam_href, 1'b0);
        chk("mid_rst_vsync", cam_vsync, 1'b0);
        chk("mid_rst_data", cam_data, 8'h00);
        chk("mid_rst_cnt", frame_cnt, 16'd0);
        chk("mid_rst_underflow", underflow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Restart and run back-to-back frames, dropping frame_en inside frame 3
        clear_stats();
        frame_en = 1'b1;
        tick();
        chk("restart_vsync", cam_vsync, 1'b1);
        repeat (55) tick();
        chk("b2b_no_gap_vsync", cam_vsync, 1'b1);
        repeat (74) tick();
        frame_en = 1'b0;
        repeat (40) tick();
        chk("b2b_done_count", n_done, 3);
        chk("b2b_done0", done_at[0], 55);
        chk("b2b_done1", done_at[1], 110);
        chk("b2b_done2", done_at[2], 165);
        chk("b2b_cnt", frame_cnt, 16'd3);
        chk("b2b_vsync_cycles", n_vs, 33);
        chk("b2b_href_cycles", n_hr, 48);
        chk("b2b_idle_after", cam_vsync, 1'b0);
        chk("b2b_underflow", underflow, 1'b0);

`ifdef CMOS_DVP_TX_TESTPAT_EN
        begin
            int         tp_ready_n;
            logic [7:0] tp_got [$];
            tp_ready_n = 0;
            tp_frame_en = 1'b1;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                tp_frame_en = 1'b0;
                if (tp_ready) tp_ready_n++;
                if (tp_href) tp_got.push_back(tp_data);
            end
            chk("tp_ready_never", tp_ready_n, 0);
            chk("tp_byte_count", tp_got.size(), 32);
            chk("tp_underflow", tp_underflow, 1'b0);
            for (int k = 0; k < 32; k++) chk($sformatf("tp_byte%0d", k), tp_got[k], tp_exp[k % 16]);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cmos_dvp_tx.md
# cmos_dvp_tx

Transmits RGB565 pixels over the 8-bit DVP camera interface: `cam_vsync`, `cam_href` and `cam_data`, all launched on `cam_pclk`. It is the sender side of the camera link. The team uses it as a camera emulator for loopback and bench testing of the capture path, and as a DVP source toward downstream boards. Pixels come from an upstream stream, or from a built-in colour-bar generator when that feature is compiled in.

## Interface
Parameters:
- `H_ACTIVE`, 640: pixels per active line (2 bytes each).
- `H_BLANK`, 144: `cam_pclk` cycles of `href`-low after each line.
- `V_ACTIVE`, 480: active lines per frame.
- `V_SYNC`, 4: lines with `vsync` high.
- `V_BACK`, 16: blank lines after sync.
- `V_FRONT`, 8: blank lines after active.

Ports:
- `cam_pclk`, in, 1: single clock. All logic is on its rising edge.
- `rst_n`, in, 1: asynchronous reset, active-low.
- `frame_en`, in, 1: when high, frames are sent back to back.
- `test_mode`, in, 1: selects the colour-bar source (needs `CMOS_DVP_TX_TESTPAT_EN`).
- `pix_data`, in, 16: RGB565 pixel.
- `pix_valid`, in, 1: `pix_data` valid.
- `pix_ready`, out, 1: one-cycle pixel request.
- `cam_vsync`, out, 1: frame sync, active-high.
- `cam_href`, out, 1: line valid.
- `cam_data`, out, 8: byte.
- `frame_done`, out, 1: one-cycle pulse at end of frame.
- `frame_cnt`, out, 16: frames completed, wraps.
- `underflow`, out, 1: sticky; set on a missed pixel.

## Operation
- `LINE_LEN` = 2*`H_ACTIVE`+`H_BLANK` cycles. Every line of every phase lasts exactly `LINE_LEN` cycles.
- FSM states: IDLE, SYNC, BACK, ACTIVE, FRONT.
  - IDLE → SYNC when `frame_en`=1.
  - SYNC → BACK after `V_SYNC` lines.
  - BACK → ACTIVE after `V_BACK` lines.
  - ACTIVE → FRONT after `V_ACTIVE` lines.
  - On the last cycle of FRONT, pulse `frame_done` and increment `frame_cnt`. Then go to SYNC if `frame_en`=1, else IDLE.
- Dropping `frame_en` mid-frame never truncates the frame. The current frame completes first.
- SYNC: `cam_vsync`=1 for all `V_SYNC`*`LINE_LEN` cycles. `cam_vsync`=0 in every other state.
- ACTIVE line:
  - `cam_href`=1 for cycles 0..2*`H_ACTIVE`-1 of the line, then 0 for `H_BLANK` cycles.
  - Even cycles carry `pix[15:8]`; odd cycles carry `pix[7:0]` (MSB byte first).
- Pixel handshake:
  - `pix_ready` pulses for one cycle, one cycle before each pixel's high byte is output.
  - On a cycle with `pix_ready`&`pix_valid`, the pixel is latched.
  - On a cycle with `pix_ready`&!`pix_valid`, the pixel is 16'h0000 and `underflow` is set.
  - `underflow` is cleared only by reset.
  - `pix_valid` is ignored when `pix_ready`=0.
- `cam_data`=8'h00 whenever `cam_href`=0.
- Counters: line counter and byte/cycle counter sized with `$clog2`. No overflow for legal parameters (all ≥1).

## Timing
- All outputs are registered. Reset value of every output is 0. FSM resets to IDLE.
- Asserting `rst_n`=0 mid-frame forces all outputs to 0 immediately. After release, the next frame starts from SYNC line 0.
- `frame_en` sampled high in IDLE → `cam_vsync`=1 on the following cycle.
- Pixel latency: `pix_ready` cycle N → high byte on `cam_data` at N+1, low byte at N+2.
- `frame_done` is coincident with the last FRONT cycle. `frame_cnt` updates on the next cycle.
- `frame_cnt` wraps 16'hFFFF → 0.
- Frame length in cycles = (`V_SYNC`+`V_BACK`+`V_ACTIVE`+`V_FRONT`)*`LINE_LEN`.

## Configuration
- `CMOS_DVP_TX_TESTPAT_EN` defined, `test_mode`=1:
  - Pixels come from 8 equal bars of `H_ACTIVE`/8 pixels each: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. The remainder pixels use the last bar.
  - `pix_ready` stays 0 and `underflow` is not updated.
  - `test_mode` is sampled only at SYNC entry.
- `CMOS_DVP_TX_TESTPAT_EN` undefined: `test_mode` is ignored, and the pixel stream is the only source.

## Structure
- Package `cmos_dvp_pkg`: FSM state enum, default timing constants, RGB565 bar colour constants.
- Sub-module `cmos_testpat_gen`, compiled only under the macro: takes the pixel index and returns the RGB565 bar colour.

## Test plan
Small parameters for all scenarios: `H_ACTIVE`=4, `H_BLANK`=3, `V_ACTIVE`=2, `V_SYNC`=1, `V_BACK`=1, `V_FRONT`=1, giving `LINE_LEN`=11 and a 55-cycle frame.
- Basic frame: `frame_en` pulsed high for one cycle in IDLE → `vsync` high for 11 cycles; `href` high for 8 cycles in lines 2 and 3; one `frame_done` at cycle 55; `frame_cnt`=1; return to IDLE.
- Byte order: pixels 1234, ABCD, 00FF, F800 always valid → `cam_data` sequence 12,34,AB,CD,00,FF,F8,00; `underflow`=0.
- Underflow: `pix_valid`=0 at the 2nd `pix_ready` → bytes 00,00 for that pixel; `underflow`=1 and it persists after the next frame.
- Back-to-back frames: `frame_en` held high → 3 frames with no IDLE gap; `frame_cnt`=3; drop `frame_en` mid-frame 3 → frame completes, then IDLE.
- Reset mid-ACTIVE: `rst_n`=0 → `href`/`vsync`/`data`/`frame_cnt`/`underflow` all 0 in the same cycle; restart begins with `vsync`.
- With `CMOS_DVP_TX_TESTPAT_EN`, `test_mode`=1, `H_ACTIVE`=8 → byte sequence FF,FF,FF,E0,07,FF,07,E0,F8,1F,F8,00,00,1F,00,00; `pix_ready` never asserted.
